alsu_pipe: RTL

Parametrised, pipelined arithmetic-logic-shift unit: the next generation of the team's 3-bit ALSU. It generalises operand width, adds valid/ready flow control on input and output, and holds the error indication until the next valid operation. Error reporting uses an LED blink divider and an optional invalid-operation counter. It sits between the operand/switch front end and the result/LED display logic.

---
 rtl/alsu_pipe.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage pipelined arithmetic/logic/shift unit with valid/ready
// flow control on both sides. Stage 1 captures the request, stage 2 is the
// result register (out/err). While err is set, leds blinks with a divider that
// restarts on every rising edge of err.
// Optional feature: define ALSU_ERR_CNT_EN to build the 8-bit saturating
// invalid-operation counter on err_cnt; otherwise err_cnt is tied to zero.
module alsu_pipe #(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int BLINK_DIV      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           opcode,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 err,
  output logic [15:0]          leds,
  output logic [7:0]           err_cnt
);

  localparam int RW = 2 * WIDTH;
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON  = (FULL_ADDER == "ON");
  localparam int DIV_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_XOR = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_SHF = 3'd4;
  localparam logic [2:0] OP_ROT = 3'd5;

  // stage 1 request register
  logic             s1_valid_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       opcode_r;
  logic             cin_r, serial_in_r, direction_r;
  logic             red_a_r, red_b_r, byp_a_r, byp_b_r;

  logic             accept_s, adv2_s;
  logic             invalid_s, red_any_s, red_use_a_s, byp_use_a_s, cin_eff_s;
  logic             err_rise_s;
  logic [WIDTH:0]   sum_s;
  logic [RW-1:0]    prod_s;
  logic [RW-1:0]    result_s;
  logic [DIV_W-1:0] div_r;

  assign adv2_s   = s1_valid_r & (~out_valid | out_ready);
  assign in_ready = ~s1_valid_r | adv2_s;
  assign accept_s = in_valid & in_ready;

  // When both flags are set the configured operand wins.
  assign red_any_s   = red_a_r | red_b_r;
  assign red_use_a_s = red_a_r & (~red_b_r | PRIO_A);
  assign byp_use_a_s = byp_a_r & (~byp_b_r | PRIO_A);
  assign cin_eff_s   = cin_r & FA_ON;

  assign invalid_s = (opcode_r == 3'd6) || (opcode_r == 3'd7) ||
                     (red_any_s && (opcode_r >= OP_ADD));

  assign sum_s  = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_eff_s};
  assign prod_s = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};

  assign err_rise_s = adv2_s & invalid_s & ~err;

  // Capture a new request into stage 1 or empty it when it moves to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      opcode_r    <= 3'd0;
      cin_r       <= 1'b0;
      serial_in_r <= 1'b0;
      direction_r <= 1'b0;
      red_a_r     <= 1'b0;
      red_b_r     <= 1'b0;
      byp_a_r     <= 1'b0;
      byp_b_r     <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r  <= 1'b1;
      a_r         <= A;
      b_r         <= B;
      opcode_r    <= opcode;
      cin_r       <= cin;
      serial_in_r <= serial_in;
      direction_r <= direction;
      red_a_r     <= red_op_A;
      red_b_r     <= red_op_B;
      byp_a_r     <= bypass_A;
      byp_b_r     <= bypass_B;
    end else if (adv2_s) begin
      s1_valid_r  <= 1'b0;
    end else begin
      s1_valid_r  <= s1_valid_r;
    end
  end

  // Result selection: invalid beats bypass, bypass beats the opcode.
  // Shift and rotate operate on the result currently held in out.
  always_comb begin
    result_s = '0;
    if (invalid_s) begin
      result_s = '0;
    end else if (byp_a_r || byp_b_r) begin
      result_s = byp_use_a_s ? {{WIDTH{1'b0}}, a_r} : {{WIDTH{1'b0}}, b_r};
    end else begin
      case (opcode_r)
        OP_AND: begin
          if (red_any_s) begin
            result_s = {{(RW-1){1'b0}}, (red_use_a_s ? (&a_r) : (&b_r))};
          end else begin
            result_s = {{WIDTH{1'b0}}, a_r & b_r};
          end
        end
        OP_XOR: begin
          if (red_any_s) begin
            result_s = {{(RW-1){1'b0}}, (red_use_a_s ? (^a_r) : (^b_r))};
          end else begin
            result_s = {{WIDTH{1'b0}}, a_r ^ b_r};
          end
        end
        OP_ADD: result_s = {{(WIDTH-1){1'b0}}, sum_s};
        OP_MUL: result_s = prod_s;
        OP_SHF: begin
          if (direction_r) begin
            result_s = {out[RW-2:0], serial_in_r};
          end else begin
            result_s = {serial_in_r, out[RW-1:1]};
          end
        end
        OP_ROT: begin
          if (direction_r) begin
            result_s = {out[RW-2:0], out[RW-1]};
          end else begin
            result_s = {out[0], out[RW-1:1]};
          end
        end
        default: result_s = '0;
      endcase
    end
  end

  // Output valid: set when stage 1 advances, cleared when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (adv2_s) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Result and error registers load only when stage 2 advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      err <= 1'b0;
    end else if (adv2_s) begin
      out <= result_s;
      err <= invalid_s;
    end else begin
      out <= out;
      err <= err;
    end
  end

  // LED blink: all-on when err rises, toggles every BLINK_DIV cycles while err
  // stays set, cleared by any valid operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds  <= 16'h0000;
      div_r <= '0;
    end else if (adv2_s && !invalid_s) begin
      leds  <= 16'h0000;
      div_r <= '0;
    end else if (err_rise_s) begin
      leds  <= 16'hFFFF;
      div_r <= '0;
    end else if (err) begin
      if (div_r == DIV_LAST) begin
        leds  <= ~leds;
        div_r <= '0;
      end else begin
        leds  <= leds;
        div_r <= div_r + DIV_W'(1);
      end
    end else begin
      leds  <= leds;
      div_r <= div_r;
    end
  end

`ifdef ALSU_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Count invalid operations as they complete, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (adv2_s && invalid_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
